conv33_stream_ctrl: RTL and testbench

- Sequencing controller for the 3x3 conv stencil datapath: input register, line buffer and 9-tap adder tree.
- Runs a valid/ready handshake on pixel input and on window-sum output.
- Tracks raster column/row and issues a single datapath advance enable, `dp_en`.
- Tags which datapath results are complete 3x3 windows, holds them in a one-entry output register, and flushes the pipeline at frame end.

---
 rtl/conv33_ctrl_pkg.sv | 20 ++
 rtl/conv33_raster_counter.sv | 37 +++
 rtl/conv33_stream_ctrl.sv | 129 ++++++++++++
 tb/tb_conv33_stream_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv33_ctrl_pkg.sv
// Shared types for the 3x3 stencil stream controller.
package conv33_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        FINISH
    } state_t;

    localparam int KSIZE  = 3;
    localparam int WIN_TH = KSIZE - 1;

    // Travels alongside each datapath advance to mark complete windows.
    typedef struct packed {
        logic win;
        logic last;
    } tag_t;

endpackage

// File: rtl/conv33_raster_counter.sv
// Raster column/row tracker for the pixel accepted next.
module conv33_raster_counter
    import conv33_ctrl_pkg::*;
#(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int CW    = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] col,
    output logic [CW-1:0] row,
    output logic          at_last
);

    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [CW-1:0] ROW_MAX = CW'(IMG_H - 1);

    assign at_last = (col == COL_MAX) && (row == ROW_MAX);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            col <= '0;
            row <= '0;
        end else if (inc) begin
            if (col == COL_MAX) begin
                col <= '0;
                row <= (row == ROW_MAX) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/conv33_stream_ctrl.sv
// 3x3 stencil sequencer: pixel handshake, datapath advance, window tagging,
// one-entry output register and end-of-frame flush.
module conv33_stream_ctrl
    import conv33_ctrl_pkg::*;
#(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int DW    = 16,
    parameter int LAT   = 1,
    localparam int CW   = $clog2((IMG_W > IMG_H) ? IMG_W : IMG_H)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          dp_en,
    input  logic [DW-1:0] sum_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic [CW-1:0] col,
    output logic [CW-1:0] row
);

    localparam int DCW = $clog2(LAT + 1);

    state_t             state, state_nxt;
    tag_t [LAT-1:0]     tag_pipe;
    tag_t               new_tag;
    logic [DCW-1:0]     drain_cnt;
    logic               clr, at_last, accept, slot_free, tag_end, stall;

    conv33_raster_counter #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .CW    (CW)
    ) u_cnt (
        .clk     (clk),
        .reset   (reset),
        .clr     (clr),
        .inc     (accept),
        .col     (col),
        .row     (row),
        .at_last (at_last)
    );

    assign accept    = in_valid && in_ready;
    assign slot_free = !out_valid || out_ready;
    assign tag_end   = tag_pipe[LAT-1].win;
    // A finished window at the pipe end must not be pushed out of a full slot.
    assign stall     = tag_end && !slot_free;
    assign busy      = (state != IDLE);

    // DRAIN advances insert {0,0} bubbles.
    assign new_tag.win  = (state == RUN) && (col >= CW'(WIN_TH)) && (row >= CW'(WIN_TH));
    assign new_tag.last = (state == RUN) && at_last;

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        dp_en     = 1'b0;
        clr       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    clr       = 1'b1;
                end
            end
            RUN: begin
                in_ready = !stall;
                dp_en    = in_valid && !stall;
                if (dp_en && at_last) state_nxt = DRAIN;
            end
            DRAIN: begin
                dp_en = !stall;
                if (dp_en && drain_cnt == DCW'(1)) state_nxt = FINISH;
            end
            FINISH: begin
                if (!out_valid) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            drain_cnt <= '0;
            done      <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= (state == FINISH) && !out_valid;
            if (state == RUN && state_nxt == DRAIN)
                drain_cnt <= DCW'(LAT);
            else if (state == DRAIN && dp_en)
                drain_cnt <= drain_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tag_pipe <= '0;
        end else if (dp_en) begin
            for (int i = LAT - 1; i > 0; i--) tag_pipe[i] <= tag_pipe[i-1];
            tag_pipe[0] <= new_tag;
        end
    end

    // sum_in is the result matching the tag at the pipe end, sampled before the advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (dp_en && tag_end) begin
            out_valid <= 1'b1;
            out_data  <= sum_in;
            out_last  <= tag_pipe[LAT-1].last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv33_stream_ctrl.sv
// Scoreboard bench: two 4x4 controllers (LAT=1 and LAT=3) with a delay-line datapath model.
module tb_conv33_stream_ctrl;

    localparam int W    = 4;
    localparam int H    = 4;
    localparam int DW   = 16;
    localparam int CW   = $clog2((W > H) ? W : H);
    localparam int NWIN = (W - 2) * (H - 2);

    typedef struct packed {
        logic          l;
        logic [DW-1:0] d;
    } exp_t;

    typedef struct packed {
        logic          win;
        logic          last;
        logic [DW-1:0] v;
    } dl_t;

    logic clk = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc_n = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input int k, input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL i%0d %s got=%0d want=%0d t=%0t", k, tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] fsum(input logic [DW-1:0] p);
        return p * 16'd37 + 16'd5;
    endfunction

    for (genvar k = 0; k < 2; k++) begin : g
        localparam int L = (k == 0) ? 1 : 3;

        logic          reset, start, in_valid, in_ready, dp_en, busy, done;
        logic          out_valid, out_ready, out_last;
        logic [DW-1:0] sum_in, out_data;
        logic [CW-1:0] col, row;

        dl_t           dl [L];
        exp_t          q [$];
        int            mc = 0, mr = 0, nout = 0, ndone = 0, nbub = 0, rel = 0, vmode = 0;
        logic [DW-1:0] pix = 1, ins_s = 0, pod = 0;
        logic          drn = 0, acc_s = 0, dp_s = 0, win_s = 0, last_s = 0;
        logic          pov = 0, pord = 0, pol = 0, pdone = 0;
        bit            vtog = 0, fin = 0;

        conv33_stream_ctrl #(
            .IMG_W (W),
            .IMG_H (H),
            .DW    (DW),
            .LAT   (L)
        ) dut (
            .clk       (clk),
            .reset     (reset),
            .start     (start),
            .busy      (busy),
            .done      (done),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .dp_en     (dp_en),
            .sum_in    (sum_in),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .out_data  (out_data),
            .out_last  (out_last),
            .col       (col),
            .row       (row)
        );

        // Datapath model: pixel delay line advanced by dp_en, window sum = fsum(pixel).
        assign sum_in = fsum(dl[L-1].v);

        always @(posedge clk) begin
            if (reset) begin
                for (int i = 0; i < L; i++) dl[i] <= '0;
            end else if (dp_s) begin
                for (int i = L - 1; i > 0; i--) dl[i] <= dl[i-1];
                dl[0] <= acc_s ? {win_s, last_s, ins_s} : '0;
            end
        end

        always @(negedge clk) begin
            logic acc, mst;
            exp_t e;
            acc = in_valid && in_ready;
            mst = dl[L-1].win && out_valid && !out_ready;
            if (reset) begin
                q.delete();
                mc = 0; mr = 0; drn = 0; nbub = 0;
                acc_s = 0; dp_s = 0; pov = 0; pdone = 0;
            end else begin
                if (busy) begin
                    if (mst) begin
                        chk(k, "stall_dp", int'(dp_en), 0);
                        chk(k, "stall_rdy", int'(in_ready), 0);
                    end else if (!drn) begin
                        chk(k, "run_rdy", int'(in_ready), 1);
                    end
                    if (!drn) chk(k, "run_dp", int'(dp_en), int'(acc));
                    else if (dp_en) nbub++;
                end else begin
                    chk(k, "idle_rdy_dp", int'({in_ready, dp_en}), 0);
                end
                if (acc) begin
                    chk(k, "col", int'(col), mc);
                    chk(k, "row", int'(row), mr);
                    win_s  = (mc >= 2 && mr >= 2);
                    last_s = (mc == W - 1 && mr == H - 1);
                    ins_s  = pix;
                    if (win_s) q.push_back({last_s, fsum(pix)});
                    if (last_s) drn = 1;
                    pix = pix + 1'b1;
                    if (mc == W - 1) begin
                        mc = 0;
                        mr = (mr == H - 1) ? 0 : mr + 1;
                    end else begin
                        mc = mc + 1;
                    end
                end
                if (out_valid && out_ready) begin
                    chk(k, "sb_nonempty", int'(q.size() > 0), 1);
                    if (q.size() > 0) begin
                        e = q.pop_front();
                        chk(k, "data", int'(out_data), int'(e.d));
                        chk(k, "last", int'(out_last), int'(e.l));
                    end
                    nout++;
                end
                if (pov && !pord) begin
                    chk(k, "hold_v", int'(out_valid), 1);
                    chk(k, "hold_d", int'(out_data), int'(pod));
                    chk(k, "hold_l", int'(out_last), int'(pol));
                end
                if (done) begin
                    chk(k, "done_busy", int'(busy), 0);
                    chk(k, "done_pulse", int'(pdone), 0);
                    chk(k, "done_sb_empty", q.size(), 0);
                    chk(k, "drain_bubbles", nbub, L);
                    ndone++;
                    drn = 0;
                    nbub = 0;
                end
                acc_s = acc;
                dp_s  = dp_en;
                pov   = out_valid;
                pord  = out_ready;
                pod   = out_data;
                pol   = out_last;
                pdone = done;
            end
        end

        initial begin
            in_valid  = 1'b0;
            out_ready = 1'b1;
            forever begin
                @(posedge clk);
                #1;
                vtog      = !vtog;
                in_valid  = (vmode == 0) ? 1'b1 : vtog;
                out_ready = (cyc_n >= rel);
            end
        end

        task automatic tick();
            @(posedge clk);
            #1;
        endtask

        task automatic finish_frame(input string tag, input int o0, input int d0);
            int n;
            n = 0;
            while (ndone == d0 && n < 400) begin
                tick();
                n++;
            end
            chk(k, {tag, "_done"}, ndone - d0, 1);
            chk(k, {tag, "_nout"}, nout - o0, NWIN);
        endtask

        task automatic run_frame(input string tag);
            int o0, d0;
            o0 = nout;
            d0 = ndone;
            start = 1'b1;
            tick();
            start = 1'b0;
            chk(k, {tag, "_busy"}, int'(busy), 1);
            chk(k, {tag, "_col0"}, int'(col), 0);
            chk(k, {tag, "_row0"}, int'(row), 0);
            finish_frame(tag, o0, d0);
        endtask

        initial begin
            int n, o0, d0;
            reset = 1'b1;
            start = 1'b0;
            repeat (3) tick();
            chk(k, "rst_busy", int'(busy), 0);
            chk(k, "rst_done", int'(done), 0);
            chk(k, "rst_ov", int'(out_valid), 0);
            chk(k, "rst_od", int'(out_data), 0);
            chk(k, "rst_col", int'(col), 0);
            chk(k, "rst_row", int'(row), 0);
            reset = 1'b0;
            tick();

            run_frame("A");

            rel = cyc_n + 40;
            run_frame("B");

            vmode = 1;
            run_frame("C");
            vmode = 0;

            // Abort mid-frame with a result stuck in the output register.
            rel = cyc_n + 100;
            start = 1'b1;
            tick();
            start = 1'b0;
            n = 0;
            while (row != 2'd3 && n < 100) begin
                tick();
                n++;
            end
            chk(k, "D_mid", int'(row), 3);
            reset = 1'b1;
            tick();
            chk(k, "D_rst_ov", int'(out_valid), 0);
            chk(k, "D_rst_busy", int'(busy), 0);
            chk(k, "D_rst_col", int'(col), 0);
            chk(k, "D_rst_row", int'(row), 0);
            reset = 1'b0;
            rel = 0;
            tick();
            run_frame("D2");

            // Start pulse while busy must be ignored.
            o0 = nout;
            d0 = ndone;
            start = 1'b1;
            tick();
            start = 1'b0;
            repeat (5) tick();
            start = 1'b1;
            tick();
            start = 1'b0;
            finish_frame("E", o0, d0);

            // Back-to-back start in the cycle after done.
            run_frame("F");
            fin = 1'b1;
        end
    end

    initial begin
        int n;
        n = 0;
        while (!(g[0].fin && g[1].fin) && n < 20000) begin
            @(posedge clk);
            n++;
        end
        chk(9, "all_finished", int'(g[0].fin && g[1].fin), 1);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
